// File: rtl/writeback_arb.sv
// Writeback arbiter: one register-file write port shared by the in-order pipe
// and a small FIFO of long-latency (mul/div) results, with the pipe always first.
`ifndef write_reg_PCp4
`define write_reg_PCp4 2'b10
`endif
`ifndef WRITE_REG_MEMD
`define WRITE_REG_MEMD 2'b01
`endif

module writeback_arb #(
  parameter int XLEN         = 32,
  parameter int RA_W         = 5,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       keep,
  input  logic                       nop,
  input  logic [XLEN-1:0]            PCp4_pype3,
  input  logic [XLEN-1:0]            mem_data_pype,
  input  logic [XLEN-1:0]            ALU_co_pype3,
  input  logic [RA_W-1:0]            WReg_pype3,
  input  logic                       RegWrite_pype3,
  input  logic [1:0]                 MemtoReg_pype3,
  input  logic                       lu_valid,
  input  logic [XLEN-1:0]            lu_data,
  input  logic [RA_W-1:0]            lu_reg,
  output logic                       lu_ready,
  output logic [XLEN-1:0]            write_reg_data,
  output logic                       Regwrite,
  output logic [RA_W-1:0]            write_reg_address,
  output logic [$clog2(LQ_DEPTH):0]  lq_count,
  output logic                       wb_stall
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LQ_DEPTH);
  localparam logic [ST_W-1:0]  STARVE_C = ST_W'(STARVE_LIMIT);

  logic              pipe_req_s;
  logic [XLEN-1:0]   pipe_data_s;
  logic              lu_ready_s;
  logic              push_s;
  logic              pop_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [ST_W-1:0]   starve_r;
  logic [ST_W-1:0]   starve_nxt_s;
  logic [XLEN-1:0]   lq_data_r [LQ_DEPTH];
  logic [RA_W-1:0]   lq_reg_r  [LQ_DEPTH];
  logic              regwrite_r;
  logic [XLEN-1:0]   wr_data_r;
  logic [RA_W-1:0]   wr_addr_r;
  logic              stall_r;

  // Pipe request qualification and result-source mux
  always_comb begin
    pipe_req_s  = ~keep & ~nop & ~RegWrite_pype3 & (WReg_pype3 != {RA_W{1'b0}});
    pipe_data_s = ALU_co_pype3;
    case (MemtoReg_pype3)
      `write_reg_PCp4: pipe_data_s = PCp4_pype3;
      `WRITE_REG_MEMD: pipe_data_s = mem_data_pype;
      default:         pipe_data_s = ALU_co_pype3;
    endcase
  end

  // FIFO handshake, pop decision and next occupancy / starvation state
  always_comb begin
    lu_ready_s  = (count_r < DEPTH_C);
    // An x0 destination still completes the handshake but is dropped here.
    push_s      = lu_valid & lu_ready_s & (lu_reg != {RA_W{1'b0}});
    pop_s       = ~pipe_req_s & (count_r != {CNT_W{1'b0}});
    count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    if ((count_r == {CNT_W{1'b0}}) || pop_s) begin
      starve_nxt_s = {ST_W{1'b0}};
    end else if (pipe_req_s && (starve_r < STARVE_C)) begin
      starve_nxt_s = starve_r + ST_W'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // FIFO storage, pointers, occupancy, starvation counter and stall request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      starve_r <= {ST_W{1'b0}};
      stall_r  <= 1'b0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_data_r[i] <= {XLEN{1'b0}};
        lq_reg_r[i]  <= {RA_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        lq_data_r[wr_ptr_r] <= lu_data;
        lq_reg_r[wr_ptr_r]  <= lu_reg;
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r  <= count_nxt_s;
      starve_r <= starve_nxt_s;
      stall_r  <= (count_nxt_s == DEPTH_C) | (starve_nxt_s >= STARVE_C);
    end
  end

  // Registered write port; address/data hold when nothing is written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_r <= 1'b0;
      wr_addr_r  <= {RA_W{1'b0}};
      wr_data_r  <= {XLEN{1'b0}};
    end else if (pipe_req_s) begin
      regwrite_r <= 1'b1;
      wr_addr_r  <= WReg_pype3;
      wr_data_r  <= pipe_data_s;
    end else if (pop_s) begin
      regwrite_r <= 1'b1;
      wr_addr_r  <= lq_reg_r[rd_ptr_r];
      wr_data_r  <= lq_data_r[rd_ptr_r];
    end else begin
      regwrite_r <= 1'b0;
    end
  end

  assign lu_ready          = lu_ready_s;
  assign Regwrite          = regwrite_r;
  assign write_reg_address = wr_addr_r;
  assign write_reg_data    = wr_data_r;
  assign lq_count          = count_r;
  assign wb_stall          = stall_r;

endmodule

// File: tb/tb_writeback_arb.sv
// Directed bench for writeback_arb: expected register-file writes are queued as
// stimulus is driven and compared one per clock edge.
`ifndef write_reg_PCp4
`define write_reg_PCp4 2'b10
`endif
`ifndef WRITE_REG_MEMD
`define WRITE_REG_MEMD 2'b01
`endif

module tb_writeback_arb;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int LQ_DEPTH = 4;
  localparam int STARVE_LIMIT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              keep;
  logic              nop;
  logic [XLEN-1:0]   PCp4_pype3;
  logic [XLEN-1:0]   mem_data_pype;
  logic [XLEN-1:0]   ALU_co_pype3;
  logic [RA_W-1:0]   WReg_pype3;
  logic              RegWrite_pype3;
  logic [1:0]        MemtoReg_pype3;
  logic              lu_valid;
  logic [XLEN-1:0]   lu_data;
  logic [RA_W-1:0]   lu_reg;
  logic              lu_ready;
  logic [XLEN-1:0]   write_reg_data;
  logic              Regwrite;
  logic [RA_W-1:0]   write_reg_address;
  logic [$clog2(LQ_DEPTH):0] lq_count;
  logic              wb_stall;

  typedef struct packed {
    logic            we;
    logic [RA_W-1:0] addr;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  writeback_arb #(
    .XLEN(XLEN), .RA_W(RA_W), .LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop),
    .PCp4_pype3(PCp4_pype3), .mem_data_pype(mem_data_pype), .ALU_co_pype3(ALU_co_pype3),
    .WReg_pype3(WReg_pype3), .RegWrite_pype3(RegWrite_pype3), .MemtoReg_pype3(MemtoReg_pype3),
    .lu_valid(lu_valid), .lu_data(lu_data), .lu_reg(lu_reg), .lu_ready(lu_ready),
    .write_reg_data(write_reg_data), .Regwrite(Regwrite),
    .write_reg_address(write_reg_address), .lq_count(lq_count), .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic [RA_W-1:0] r, input logic [XLEN-1:0] d);
    exp_q.push_back('{we: 1'b1, addr: r, data: d});
  endtask

  task automatic exp_idle();
    exp_q.push_back('{we: 1'b0, addr: {RA_W{1'b0}}, data: {XLEN{1'b0}}});
  endtask

  // Advance one edge and compare the write port against the oldest expectation.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("regwrite", 32'(Regwrite), 32'(e.we));
      if (e.we) begin
        chk("wr_addr", 32'(write_reg_address), 32'(e.addr));
        chk("wr_data", write_reg_data, e.data);
      end
    end
  endtask

  task automatic pipe_wr(input logic [RA_W-1:0] r, input logic [1:0] sel, input logic [XLEN-1:0] d);
    keep           = 1'b0;
    nop            = 1'b0;
    RegWrite_pype3 = 1'b0;
    WReg_pype3     = r;
    MemtoReg_pype3 = sel;
    PCp4_pype3     = 32'h0000_1111;
    mem_data_pype  = 32'h0000_2222;
    ALU_co_pype3   = 32'h0000_3333;
    case (sel)
      `write_reg_PCp4: PCp4_pype3 = d;
      `WRITE_REG_MEMD: mem_data_pype = d;
      default:         ALU_co_pype3 = d;
    endcase
  endtask

  task automatic pipe_off();
    keep           = 1'b0;
    nop            = 1'b0;
    RegWrite_pype3 = 1'b1;
  endtask

  task automatic lu_push(input logic [RA_W-1:0] r, input logic [XLEN-1:0] d);
    lu_valid = 1'b1;
    lu_reg   = r;
    lu_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pipe_off();
    WReg_pype3 = 5'd0;
    MemtoReg_pype3 = 2'b00;
    PCp4_pype3 = 32'd0;
    mem_data_pype = 32'd0;
    ALU_co_pype3 = 32'd0;
    lu_valid = 1'b0;
    lu_reg = 5'd0;
    lu_data = 32'd0;
    #12;
    chk("rst_regwrite", 32'(Regwrite), 32'd0);
    chk("rst_data", write_reg_data, 32'd0);
    chk("rst_addr", 32'(write_reg_address), 32'd0);
    chk("rst_count", 32'(lq_count), 32'd0);
    chk("rst_stall", 32'(wb_stall), 32'd0);
    rst = 1'b0;
    chk("rst_ready", 32'(lu_ready), 32'd1);

    // Pipe writes from each source
    pipe_wr(5'd5, `WRITE_REG_MEMD, 32'hDEAD_BEEF); exp_wr(5'd5, 32'hDEAD_BEEF); tick();
    pipe_wr(5'd6, `write_reg_PCp4, 32'h0000_0104); exp_wr(5'd6, 32'h0000_0104); tick();
    pipe_wr(5'd7, 2'b00, 32'h0000_0055);           exp_wr(5'd7, 32'h0000_0055); tick();
    pipe_wr(5'd7, 2'b11, 32'h0000_0066);           exp_wr(5'd7, 32'h0000_0066); tick();

    // x0 destination and the various bubble forms
    pipe_wr(5'd0, 2'b00, 32'h0000_0077); exp_idle(); tick();
    chk("hold_data", write_reg_data, 32'h0000_0066);
    chk("hold_addr", 32'(write_reg_address), 32'd7);
    pipe_wr(5'd8, 2'b00, 32'h0000_0088); nop = 1'b1;  exp_idle(); tick();
    pipe_wr(5'd8, 2'b00, 32'h0000_0088); keep = 1'b1; exp_idle(); tick();
    pipe_wr(5'd8, 2'b00, 32'h0000_0088); keep = 1'b1; nop = 1'b1; exp_idle(); tick();
    pipe_wr(5'd8, 2'b00, 32'h0000_0088); RegWrite_pype3 = 1'b1; exp_idle(); tick();
    pipe_off();
    lu_push(5'd0, 32'h0000_0999); exp_idle(); tick();
    lu_valid = 1'b0;
    chk("x0_lu_count", 32'(lq_count), 32'd0);
    exp_idle(); tick();

    // Fill the FIFO while the pipe writes every cycle
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", 32'(lu_ready), 32'd1);
      pipe_wr(5'd9, 2'b00, 32'h900 + 32'(i));
      lu_push(5'(i + 1), 32'h11 * 32'(i + 1));
      exp_wr(5'd9, 32'h900 + 32'(i));
      tick();
    end
    chk("full_count", 32'(lq_count), 32'd4);
    chk("full_ready", 32'(lu_ready), 32'd0);
    chk("full_stall", 32'(wb_stall), 32'd1);
    pipe_wr(5'd9, 2'b00, 32'h0000_0909); lu_push(5'd5, 32'h0000_0055);
    exp_wr(5'd9, 32'h0000_0909); tick();
    chk("full_hold_count", 32'(lq_count), 32'd4);
    chk("full_hold_ready", 32'(lu_ready), 32'd0);
    lu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pipe_wr(5'd9, 2'b00, 32'h0000_0999); nop = 1'b1;
      exp_wr(5'(i + 1), 32'h11 * 32'(i + 1));
      tick();
    end
    chk("drain_count", 32'(lq_count), 32'd0);
    chk("drain_stall", 32'(wb_stall), 32'd0);

    // Simultaneous push/pop at count=2 with pointer wrap
    pipe_wr(5'd9, 2'b00, 32'h0000_0A00); lu_push(5'd10, 32'h0000_00A0);
    exp_wr(5'd9, 32'h0000_0A00); tick();
    pipe_wr(5'd9, 2'b00, 32'h0000_0A01); lu_push(5'd11, 32'h0000_00B0);
    exp_wr(5'd9, 32'h0000_0A01); tick();
    chk("pp_count0", 32'(lq_count), 32'd2);
    pipe_off();
    for (int i = 0; i < 4; i++) begin
      lu_push(5'(12 + i), 32'hC0 + 32'h10 * 32'(i));
      exp_wr(5'(10 + i), 32'hA0 + 32'h10 * 32'(i));
      tick();
      chk("pp_count", 32'(lq_count), 32'd2);
    end
    lu_valid = 1'b0;
    exp_wr(5'd14, 32'h0000_00E0); tick();
    exp_wr(5'd15, 32'h0000_00F0); tick();
    chk("pp_empty", 32'(lq_count), 32'd0);

    // Minimum latency from push to write
    lu_push(5'd16, 32'h0000_1600); exp_idle(); tick();
    lu_valid = 1'b0;
    chk("lat_count", 32'(lq_count), 32'd1);
    exp_wr(5'd16, 32'h0000_1600); tick();
    chk("lat_empty", 32'(lq_count), 32'd0);

    // Starvation: stall after 8 blocked cycles, clears on the pop
    lu_push(5'd17, 32'h0000_1700); exp_idle(); tick();
    lu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pipe_wr(5'd20, `WRITE_REG_MEMD, 32'h2000 + 32'(i));
      exp_wr(5'd20, 32'h2000 + 32'(i));
      tick();
      chk("starve_stall", 32'(wb_stall), (i == 7) ? 32'd1 : 32'd0);
    end
    pipe_off();
    exp_wr(5'd17, 32'h0000_1700); tick();
    chk("starve_clr_stall", 32'(wb_stall), 32'd0);
    chk("starve_clr_count", 32'(lq_count), 32'd0);

    // Counter restarts from zero and saturates
    lu_push(5'd18, 32'h0000_1800); exp_idle(); tick();
    lu_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pipe_wr(5'd21, 2'b00, 32'h3000 + 32'(i));
      exp_wr(5'd21, 32'h3000 + 32'(i));
      tick();
      chk("starve2_stall", 32'(wb_stall), (i >= 7) ? 32'd1 : 32'd0);
    end
    nop = 1'b1;
    exp_wr(5'd18, 32'h0000_1800); tick();
    chk("starve2_clr", 32'(wb_stall), 32'd0);

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 4; i++) begin
      pipe_wr(5'd9, 2'b00, 32'h4000 + 32'(i));
      lu_push(5'(21 + i), 32'h2100 + 32'(i));
      exp_wr(5'd9, 32'h4000 + 32'(i));
      tick();
    end
    lu_valid = 1'b0;
    pipe_off();
    exp_wr(5'd21, 32'h0000_2100); tick();
    chk("pre_rst_count", 32'(lq_count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_regwrite", 32'(Regwrite), 32'd0);
    chk("arst_count", 32'(lq_count), 32'd0);
    chk("arst_data", write_reg_data, 32'd0);
    chk("arst_addr", 32'(write_reg_address), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    exp_idle(); tick();
    exp_idle(); tick();
    chk("post_rst_count", 32'(lq_count), 32'd0);
    chk("post_rst_stall", 32'(wb_stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
